// File: rtl/jpeg_stuff_pkg.sv
// Shared types and helpers for the JPEG 0xFF byte stuffer: FSM states,
// FIFO entry layout and the end-of-image padding rules.
package jpeg_stuff_pkg;

  localparam logic [7:0] FF_BYTE    = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, STUFF, FLUSH} stuff_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  nbytes;
    logic        last;
  } fifo_entry_t;

  // orc valid bits sit at the top of the word; everything below them becomes 1
  function automatic logic [31:0] pad_word(input logic [31:0] word, input logic [4:0] orc);
    return word | (32'hFFFF_FFFF >> orc);
  endfunction

  function automatic logic [2:0] pad_nbytes(input logic [4:0] orc);
    logic [5:0] t;
    t = {1'b0, orc} + 6'd7;
    return t[5:3];
  endfunction

endpackage

// File: rtl/jpeg_ff_stuffer_fifo.sv
// Synchronous FIFO of stuffer entries; head is visible combinationally on rd_data.
module stuff_fifo
  import jpeg_stuff_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  logic [AW:0] wr_ptr, rd_ptr;
  fifo_entry_t mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/jpeg_ff_stuffer.sv
// JPEG entropy-segment stuffer: queues encoder words, inserts 0x00 after each
// 0xFF byte, pads the final partial word and repacks into 32-bit ready/valid words.
module jpeg_ff_stuffer
  import jpeg_stuff_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        eoi,
  input  logic [4:0]  orc_in,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        overflow,
  output logic        busy
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);

  logic         eoi_pend;
  logic [31:0]  pend_data;
  logic [4:0]   pend_orc;
  logic         wr_en, rd_en, fifo_full, fifo_empty;
  fifo_entry_t  wr_entry, head;

  stuff_state_t state, nstate, entry_next;
  logic [31:0]  sh;
  logic [1:0]   idx;
  logic [2:0]   nb;
  logic         lst;
  logic [31:0]  pk_data, pk_merge;
  logic [2:0]   pk_cnt;
  logic         out_free, pk_full, stall, last_byte, is_ff;
  logic         push, take, adv, flush_go;
  logic [7:0]   push_byte;

  // ---------------- FIFO write side ----------------
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = '0;
    if (data_valid) begin
      wr_en    = 1'b1;
      wr_entry = '{word: data_in, nbytes: 3'd4, last: 1'b0};
    end else if (eoi_pend) begin
      wr_en    = 1'b1;
      wr_entry = '{word: pad_word(pend_data, pend_orc), nbytes: pad_nbytes(pend_orc), last: 1'b1};
    end else if (eoi) begin
      wr_en    = 1'b1;
      wr_entry = '{word: pad_word(data_in, orc_in), nbytes: pad_nbytes(orc_in), last: 1'b1};
    end
  end

  // An eoi colliding with a word is parked until the first cycle without data_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eoi_pend  <= 1'b0;
      pend_data <= '0;
      pend_orc  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (data_valid && eoi && !eoi_pend) begin
        eoi_pend  <= 1'b1;
        pend_data <= data_in;
        pend_orc  <= orc_in;
      end else if (!data_valid && eoi_pend) begin
        eoi_pend  <= 1'b0;
      end
      if (wr_en && fifo_full) overflow <= 1'b1;
    end
  end

  stuff_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---------------- engine FSM ----------------
  assign out_free   = !out_valid || out_ready;
  assign pk_full    = (pk_cnt == 3'd4);
  assign stall      = pk_full && !out_free;
  assign last_byte  = ({1'b0, idx} == (nb - 3'd1));
  assign is_ff      = (state == EMIT) && (sh[31:24] == FF_BYTE);
  assign entry_next = (head.nbytes == 3'd0) ? (head.last ? FLUSH : IDLE) : EMIT;
  assign rd_en      = take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (!fifo_empty) nstate = LOAD;
      LOAD:  nstate = entry_next;
      EMIT, STUFF:
        if (!stall) begin
          if (is_ff)           nstate = STUFF;
          else if (!last_byte) nstate = EMIT;
          else if (lst)        nstate = FLUSH;
          else if (take)       nstate = entry_next;
          else                 nstate = IDLE;
        end
      FLUSH: if (flush_go) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Finishing a non-final entry pops the next one directly, keeping 1 byte/cycle
  always_comb begin
    push      = 1'b0;
    push_byte = STUFF_BYTE;
    take      = 1'b0;
    adv       = 1'b0;
    flush_go  = 1'b0;
    case (state)
      LOAD: take = 1'b1;
      EMIT, STUFF:
        if (!stall) begin
          push = 1'b1;
          if (state == EMIT) push_byte = sh[31:24];
          if (!is_ff) begin
            if (!last_byte)                adv  = 1'b1;
            else if (!lst && !fifo_empty)  take = 1'b1;
          end
        end
      FLUSH: flush_go = !pk_full && out_free;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh  <= '0;
      idx <= '0;
      nb  <= '0;
      lst <= 1'b0;
    end else if (take) begin
      sh  <= head.word;
      idx <= '0;
      nb  <= head.nbytes;
      lst <= head.last;
    end else if (adv) begin
      sh  <= {sh[23:0], 8'h00};
      idx <= idx + 2'd1;
    end
  end

  // ---------------- packer and output register ----------------
  assign pk_merge = pk_data | ({push_byte, 24'h0} >> {pk_cnt, 3'b000});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pk_data   <= '0;
      pk_cnt    <= '0;
      out_data  <= '0;
      out_bytes <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush_go) begin
      out_data  <= pk_data;
      out_bytes <= pk_cnt;
      out_last  <= 1'b1;
      out_valid <= 1'b1;
      pk_data   <= '0;
      pk_cnt    <= '0;
    end else if (pk_full && out_free) begin
      out_data  <= pk_data;
      out_bytes <= 3'd4;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      pk_data   <= push ? {push_byte, 24'h0} : '0;
      pk_cnt    <= push ? 3'd1 : 3'd0;
    end else if (push && pk_cnt == 3'd3 && out_free) begin
      // the fourth byte goes straight into the output register
      out_data  <= pk_merge;
      out_bytes <= 3'd4;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      pk_data   <= '0;
      pk_cnt    <= '0;
    end else begin
      if (push) begin
        pk_data <= pk_merge;
        pk_cnt  <= pk_cnt + 3'd1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign busy = !fifo_empty || (state != IDLE) || out_valid;

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Randomised bench for jpeg_ff_stuffer: a byte-queue model pads, stuffs and
// repacks each image; a negedge monitor checks every accepted output word.
module tb_jpeg_ff_stuffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_valid, eoi, out_ready;
  logic [4:0]  orc_in;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_valid, out_last, overflow, busy;

  always #5 clk = ~clk;

  jpeg_ff_stuffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .eoi(eoi), .orc_in(orc_in), .out_data(out_data), .out_bytes(out_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  n;
    logic        l;
  } ow_t;

  ow_t        expq[$];
  ow_t        gotq[$];
  logic [7:0] mbuf[$];
  int         checks = 0, errors = 0;
  bit         capture = 0, rnd_ready = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic m_byte(input logic [7:0] b);
    ow_t o;
    mbuf.push_back(b);
    if (b == 8'hFF) mbuf.push_back(8'h00);
    while (mbuf.size() >= 4) begin
      o.d = {mbuf[0], mbuf[1], mbuf[2], mbuf[3]};
      o.n = 3'd4;
      o.l = 1'b0;
      expq.push_back(o);
      repeat (4) void'(mbuf.pop_front());
    end
  endtask

  task automatic m_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) m_byte(w[31-8*i -: 8]);
  endtask

  task automatic m_final(input logic [31:0] w, input int orc);
    logic [31:0] p;
    ow_t o;
    int nbytes;
    p = w;
    for (int b = orc; b < 32; b++) p[31-b] = 1'b1;
    nbytes = (orc + 7) / 8;
    for (int i = 0; i < nbytes; i++) m_byte(p[31-8*i -: 8]);
    o.d = '0;
    for (int i = 0; i < mbuf.size(); i++) o.d[31-8*i -: 8] = mbuf[i];
    o.n = 3'(mbuf.size());
    o.l = 1'b1;
    expq.push_back(o);
    mbuf.delete();
  endtask

  // ---------------- monitor and random ready ----------------
  initial forever begin
    @(negedge clk);
    if (rst && out_valid && out_ready) begin
      ow_t o;
      o.d = out_data; o.n = out_bytes; o.l = out_last;
      if (capture) gotq.push_back(o);
      else if (expq.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else begin
        ow_t e;
        e = expq.pop_front();
        chk("out_data", o.d, e.d);
        chk("out_bytes", o.n, e.n);
        chk("out_last", o.l, e.l);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    m_word(w);
    data_in = w; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_eoi(input logic [31:0] w, input int orc);
    m_final(w, orc);
    data_in = w; orc_in = 5'(orc); eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  // one data bus carries both the full word and the parked partial word
  task automatic send_collision(input logic [31:0] w, input int orc);
    m_word(w);
    m_final(w, orc);
    data_in = w; orc_in = 5'(orc); data_valid = 1'b1; eoi = 1'b1;
    tick();
    data_valid = 1'b0; eoi = 1'b0;
  endtask

  task automatic latency_word(input logic [31:0] w, input string tag);
    m_word(w);
    data_in = w; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk({tag, "_early"}, out_valid, 1'b0);
    @(posedge clk);
    #1 chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, w);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || expq.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, n < 3000, 1'b1);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    for (int b = 0; b < 4; b++)
      w[31-8*b -: 8] = ($urandom_range(0, 9) < 4) ? 8'hFF : 8'($urandom);
    return w;
  endfunction

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b0; data_in = '0; data_valid = 1'b0; eoi = 1'b0; orc_in = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_bytes", out_bytes, 3'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b1;
    tick();

    // single word, then empty final word
    latency_word(32'h1234_5678, "lat1");
    send_eoi(32'h0, 0);
    wait_idle("t1");

    // stuffing across a word boundary
    send_word(32'hFF00_FF11);
    send_eoi(32'h0, 0);
    wait_idle("t2");

    // padding, including padding that produces 0xFF
    send_eoi(32'hA000_0000, 3);
    wait_idle("t3a");
    send_eoi(32'hE000_0000, 3);
    wait_idle("t3b");

    // word and eoi in the same cycle
    send_collision(32'h9122_3344, 1);
    wait_idle("t5");

    // random images with random backpressure
    rnd_ready = 1'b1;
    for (int img = 0; img < 25; img++) begin
      int nw;
      bit col;
      nw  = $urandom_range(0, 5);
      col = (nw > 0) && ($urandom_range(0, 2) == 0);
      for (int k = 0; k < nw; k++) begin
        if (col && k == nw - 1) send_collision(rnd_word(), $urandom_range(0, 31));
        else send_word(rnd_word());
        repeat ($urandom_range(0, 2)) tick();
      end
      if (!col) begin
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 1) == 1) p[31:24] = 8'hFF;
        send_eoi(p, $urandom_range(0, 31));
      end
      wait_idle("rnd");
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("rnd_no_ovf", overflow, 1'b0);

    // overflow under backpressure; kept words must be an unbroken prefix
    out_ready = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      data_in = 32'h0101_0101 * k; data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, 32'h0101_0101);
      tick();
    end
    chk("ovf_set", overflow, 1'b1);
    capture = 1'b1;
    out_ready = 1'b1;
    wait_idle("t4a");
    data_in = '0; orc_in = '0; eoi = 1'b1;
    tick();
    eoi = 1'b0;
    wait_idle("t4b");
    repeat (2) tick();
    capture = 1'b0;
    begin
      int kept;
      kept = gotq.size() - 1;
      chk("ovf_kept", (kept >= DEPTH + 1) && (kept <= DEPTH + 4), 1'b1);
      for (int i = 0; i < kept && i < gotq.size(); i++) begin
        chk("ovf_word", gotq[i].d, 32'h0101_0101 * (i + 1));
        chk("ovf_last", gotq[i].l, 1'b0);
      end
      if (gotq.size() > 0) begin
        chk("ovf_final_last", gotq[gotq.size()-1].l, 1'b1);
        chk("ovf_final_bytes", gotq[gotq.size()-1].n, 3'd0);
      end
    end
    chk("ovf_sticky", overflow, 1'b1);

    // reset in the middle of stuffing
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_in = 32'hFFFF_FFFF; data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_bytes", out_bytes, 3'd0);
    chk("mid_rst_last", out_last, 1'b0);
    chk("mid_rst_ovf", overflow, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    expq.delete();
    mbuf.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    latency_word(32'h0BAD_C0DE, "lat2");
    send_eoi(32'h0, 0);
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
